ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute pipeline stage. Sits between the decode stage and the memory stage.
- Maps decoded instruction fields to the 6-bit ALU op code and drives the combinational ALU instance. It also selects the ALU operands.
- Captures the ALU result Q and the compare bit CMP into the EX/MEM register under a valid/ready handshake.
- Resolves branches and jumps, and issues a one-cycle PC redirect.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_NEXT, 32'h0000_0000, value of redirect_pc after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_pc  in  XLEN  instruction address.
- in_rs1 / in_rs2  in  XLEN  register operands.
- in_imm  in  XLEN  sign-extended immediate.
- in_opcode  in  7  RV32I opcode.
- in_funct3  in  3  funct3.
- in_funct7b5  in  1  instruction bit 30.
- in_rd  in  5  destination register.
- flush  in  1  synchronous kill of the stage contents.
- alu_s  out  6  ALU op code.
- alu_a / alu_b  out  XLEN  ALU operands.
- alu_q  in  XLEN  ALU result.
- alu_cmp  in  1  ALU compare bit.
- out_valid  out  1  EX/MEM register holds a valid instruction.
- out_ready  in  1  memory stage accepts.
- out_result  out  XLEN  ALU result or link address.
- out_store_data  out  XLEN  rs2, forwarded for stores.
- out_rd  out  5  destination register.
- out_wb_en  out  1  register write enable.
- out_mem_rd / out_mem_wr  out  1  load / store.
- out_funct3  out  3  memory access size.
- out_illegal  out  1  unknown opcode.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- out_misalign  out  1  taken target has bit 1 set.

Behaviour:
- ALU op code:
  - alu_s[0] = 1.
  - alu_s[1] = 1 for BRANCH, else 0.
  - alu_s[4:2] = funct3 for OP, OP-IMM and BRANCH.
  - alu_s[5] = funct7b5 for OP; for OP-IMM only when funct3 = 101 (SRAI), else 0; 0 for BRANCH.
  - All other opcodes use the ADD code, 6'b000001.
- Operand select:
  - OP, BRANCH: a = rs1, b = rs2.
  - OP-IMM, LOAD, STORE, JALR: a = rs1, b = imm.
  - AUIPC: a = pc, b = imm.
  - LUI: a = 0, b = imm.
  - JAL: a = pc, b = imm, used as the target; the result is pc+4.
- Handshake:
  - in_ready = !out_valid | out_ready | redirect_valid.
  - An instruction is accepted when in_valid & in_ready & !flush & !redirect_valid.
  - While out_valid & !out_ready, all out_* registers hold stable.
  - On out_ready with no new acceptance, out_valid falls to 0 on the next edge.
- Latency: 1 cycle. Fields accepted at edge N appear on out_* after edge N.
- Writeback:
  - out_wb_en = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd != 0.
  - out_result = pc+4 for JAL and JALR, else alu_q.
- Branch resolution (registered):
  - BRANCH with alu_cmp = 1, JAL, or JALR → redirect_valid = 1 for exactly one cycle after acceptance.
  - redirect_pc = pc+imm for BRANCH and JAL; (rs1+imm) & ~1 for JALR.
  - out_misalign = redirect_pc[1] for that instruction.
- Shadow kill:
  - In the cycle redirect_valid = 1, any in_valid is consumed (in_ready = 1) and discarded, because it is the wrong-path instruction.
  - The output register still updates/drains normally, gated by out_ready.
- Illegal opcode: accepted with out_illegal = 1, wb/mem enables = 0, and no redirect.
- flush:
  - Next edge: out_valid = 0 and redirect_valid = 0; the current input is discarded.
  - flush overrides both acceptance and redirect generation in the same cycle.
- Reset (asynchronous):
  - out_valid, redirect_valid, out_wb_en, out_mem_rd, out_mem_wr, out_illegal and out_misalign = 0.
  - Data outputs = 0; redirect_pc = RESET_PC_NEXT.
  - Reset mid-stall drops the held instruction.
- Arithmetic: all adds are modulo 2^XLEN; pc+4 wraps at 32'hFFFF_FFFC → 0.

Test Plan:
- ADD x5 from rs1 = 7 and rs2 = 3; SUB with funct7b5 = 1 → alu_s = 000001 then 100001; out_result = 10 then 4; out_wb_en = 1; out_rd = 5.
- SRAI with rs1 = 32'h8000_0000 and imm shamt 4 (funct7b5 = 1) → alu_s = 110101; out_result = 32'hF800_0000. ADDI with bit 30 set → alu_s = 000001.
- BEQ with pc = 0x100, imm = 0x20, rs1 = rs2 = 9, next in_valid held → redirect_valid for one cycle with redirect_pc = 0x120; the shadow instruction is discarded and the next accepted instruction appears after it.
- JALR with rs1 = 0x203 and imm = 0, rd = 1 → redirect_pc = 0x202, out_misalign = 1, out_result = pc+4. Same with rd = 0 → out_wb_en = 0.
- out_ready low for 3 cycles with in_valid high → in_ready = 0 and out_* stable; on release, two back-to-back instructions emerge in order with none lost.
- flush asserted together with a taken BNE, then rst pulsed mid-stall → no redirect, out_valid = 0; after reset all flags = 0 and redirect_pc = RESET_PC_NEXT.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: decodes ALU op and operands, resolves branches/jumps, and holds
// the EX/MEM pipeline register behind a valid/ready handshake.
module ex_stage #(
  parameter int                XLEN          = 32,
  parameter logic [XLEN-1:0]   RESET_PC_NEXT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic [5:0]      alu_s,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_q,
  input  logic            alu_cmp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_funct3,
  output logic            out_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            out_misalign
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] pc_imm, pc_plus4, jalr_target, target;
  logic            is_legal, wb_dec, mem_rd_dec, mem_wr_dec, link, taken, accept;

  // Targets get dedicated adders so the ALU stays free to do the branch compare.
  assign pc_imm      = in_pc + in_imm;
  assign pc_plus4    = in_pc + XLEN'(4);
  assign jalr_target = (in_rs1 + in_imm) & ~XLEN'(1);

  always_comb begin
    alu_s      = 6'b000001;
    alu_a      = in_rs1;
    alu_b      = in_imm;
    is_legal   = 1'b1;
    wb_dec     = 1'b0;
    mem_rd_dec = 1'b0;
    mem_wr_dec = 1'b0;
    link       = 1'b0;
    taken      = 1'b0;
    target     = pc_imm;
    case (in_opcode)
      OPC_OP: begin
        alu_s  = {in_funct7b5, in_funct3, 2'b01};
        alu_b  = in_rs2;
        wb_dec = 1'b1;
      end
      OPC_IMM: begin
        alu_s  = {in_funct7b5 & (in_funct3 == 3'b101), in_funct3, 2'b01};
        wb_dec = 1'b1;
      end
      OPC_BRANCH: begin
        alu_s = {1'b0, in_funct3, 2'b11};
        alu_b = in_rs2;
        taken = alu_cmp;
      end
      OPC_LOAD: begin
        wb_dec     = 1'b1;
        mem_rd_dec = 1'b1;
      end
      OPC_STORE: mem_wr_dec = 1'b1;
      OPC_JAL: begin
        alu_a  = in_pc;
        wb_dec = 1'b1;
        link   = 1'b1;
        taken  = 1'b1;
      end
      OPC_JALR: begin
        wb_dec = 1'b1;
        link   = 1'b1;
        taken  = 1'b1;
        target = jalr_target;
      end
      OPC_AUIPC: begin
        alu_a  = in_pc;
        wb_dec = 1'b1;
      end
      OPC_LUI: begin
        alu_a  = '0;
        wb_dec = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

  // A live redirect means the instruction now on the input is wrong-path: take it and drop it.
  assign in_ready = ~out_valid | out_ready | redirect_valid;
  assign accept   = in_valid & in_ready & ~flush & ~redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_wb_en      <= 1'b0;
      out_mem_rd     <= 1'b0;
      out_mem_wr     <= 1'b0;
      out_funct3     <= '0;
      out_illegal    <= 1'b0;
      out_misalign   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC_NEXT;
    end else if (flush) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= accept & taken;
      if (accept) begin
        out_valid      <= 1'b1;
        out_result     <= link ? pc_plus4 : alu_q;
        out_store_data <= in_rs2;
        out_rd         <= in_rd;
        out_wb_en      <= wb_dec & (in_rd != 5'd0);
        out_mem_rd     <= mem_rd_dec;
        out_mem_wr     <= mem_wr_dec;
        out_funct3     <= in_funct3;
        out_illegal    <= ~is_legal;
        out_misalign   <= taken & target[1];
        if (taken) redirect_pc <= target;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes model predictions, a negedge monitor
// compares them against the EX/MEM register and the redirect pulse.
module tb_ex_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_IMM    = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_BAD    = 7'b1110011;

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic [31:0] result;
    logic        result_dc;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        wb, mrd, mwr;
    logic [2:0]  f3;
    logic        ill, mis, taken;
    logic [31:0] target;
  } exp_t;

  logic        clk, rst, in_valid, in_ready, in_funct7b5, flush, alu_cmp;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, alu_a, alu_b, alu_q;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3, out_funct3;
  logic [4:0]  in_rd, out_rd;
  logic [5:0]  alu_s;
  logic        out_valid, out_ready, out_wb_en, out_mem_rd, out_mem_wr, out_illegal;
  logic        redirect_valid, out_misalign;
  logic [31:0] out_result, out_store_data, redirect_pc;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_shadow   = 1'b0;
  logic        drop_pending = 1'b0;

  ex_stage #(.XLEN(32), .RESET_PC_NEXT(RESET_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd), .flush(flush),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q), .alu_cmp(alu_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_funct3(out_funct3),
    .out_illegal(out_illegal), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_misalign(out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // External combinational ALU: compare mode subtracts and raises cmp per funct3.
  function automatic logic [31:0] alu_fn(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    return s[1] ? a - b : arith(s[4:2], s[5], a, b);
  endfunction

  assign alu_q   = alu_fn(alu_s, alu_a, alu_b);
  assign alu_cmp = alu_s[1] & br_cond(alu_s[4:2], alu_a, alu_b);

  function automatic exp_t ref_model(input instr_t i);
    exp_t e;
    e.result = 32'd0; e.result_dc = 1'b0; e.store_data = i.rs2; e.rd = i.rd; e.f3 = i.f3;
    e.wb = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.ill = 1'b0; e.taken = 1'b0; e.target = 32'd0;
    case (i.op)
      OPC_OP:     begin e.result = arith(i.f3, i.f7, i.rs1, i.rs2); e.wb = 1'b1; end
      OPC_IMM:    begin e.result = arith(i.f3, i.f7 && i.f3 == 3'b101, i.rs1, i.imm); e.wb = 1'b1; end
      OPC_LOAD:   begin e.result = i.rs1 + i.imm; e.wb = 1'b1; e.mrd = 1'b1; end
      OPC_STORE:  begin e.result = i.rs1 + i.imm; e.mwr = 1'b1; end
      OPC_LUI:    begin e.result = i.imm; e.wb = 1'b1; end
      OPC_AUIPC:  begin e.result = i.pc + i.imm; e.wb = 1'b1; end
      OPC_JAL:    begin e.result = i.pc + 32'd4; e.wb = 1'b1; e.taken = 1'b1; e.target = i.pc + i.imm; end
      OPC_JALR:   begin e.result = i.pc + 32'd4; e.wb = 1'b1; e.taken = 1'b1;
                        e.target = (i.rs1 + i.imm) & 32'hFFFF_FFFE; end
      OPC_BRANCH: begin e.result = i.rs1 - i.rs2; e.taken = br_cond(i.f3, i.rs1, i.rs2);
                        e.target = i.pc + i.imm; end
      default:    begin e.ill = 1'b1; e.result_dc = 1'b1; end
    endcase
    if (i.rd == 5'd0) e.wb = 1'b0;
    e.mis = e.taken & e.target[1];
    return e;
  endfunction

  function automatic logic [5:0] exp_alu_s(input instr_t i);
    case (i.op)
      OPC_OP:     return {i.f7, i.f3, 2'b01};
      OPC_IMM:    return {(i.f3 == 3'b101) ? i.f7 : 1'b0, i.f3, 2'b01};
      OPC_BRANCH: return {1'b0, i.f3, 2'b11};
      default:    return 6'b000001;
    endcase
  endfunction

  function automatic logic [63:0] exp_operands(input instr_t i);
    case (i.op)
      OPC_OP, OPC_BRANCH:  return {i.rs1, i.rs2};
      OPC_AUIPC, OPC_JAL:  return {i.pc, i.imm};
      OPC_LUI:             return {32'd0, i.imm};
      default:             return {i.rs1, i.imm};
    endcase
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm);
    instr_t i;
    i.op = op; i.f3 = f3; i.f7 = f7; i.rd = rd; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.pc  = $urandom & 32'hFFFF_FFFC;
    i.rs1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
    i.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
    i.f3  = 3'($urandom);
    i.f7  = 1'($urandom);
    i.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 9))
      0: i.op = OPC_OP;     1: i.op = OPC_IMM;  2: i.op = OPC_LOAD;
      3: i.op = OPC_STORE;  4: i.op = OPC_BRANCH; 5: i.op = OPC_JAL;
      6: i.op = OPC_JALR;   7: i.op = OPC_LUI;  8: i.op = OPC_AUIPC;
      default: i.op = OPC_BAD;
    endcase
    if (i.op == OPC_BRANCH && i.f3[2:1] == 2'b01) i.f3[2] = 1'b1;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; decides from the model whether the input was taken or shadow-killed.
  task automatic applyStimulus(input instr_t ins, input logic v, input logic ordy,
                               input logic fl, output logic consumed);
    exp_t        e;
    logic        nxt;
    logic [63:0] ops;
    @(posedge clk); #1;
    if (drop_pending) begin
      exp_q.delete();
      drop_pending = 1'b0;
    end
    in_valid = v; in_pc = ins.pc; in_rs1 = ins.rs1; in_rs2 = ins.rs2; in_imm = ins.imm;
    in_opcode = ins.op; in_funct3 = ins.f3; in_funct7b5 = ins.f7; in_rd = ins.rd;
    out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    consumed = 1'b0;
    nxt      = 1'b0;
    if (v && !fl) begin
      if (exp_shadow) begin
        checkOutput("shadow_in_ready", 32'(in_ready), 32'd1);
        consumed = 1'b1;
      end else if (in_ready) begin
        consumed = 1'b1;
        e = ref_model(ins);
        checkOutput("alu_s", 32'(alu_s), 32'(exp_alu_s(ins)));
        if (!e.ill) begin
          ops = exp_operands(ins);
          checkOutput("alu_a", alu_a, ops[63:32]);
          checkOutput("alu_b", alu_b, ops[31:0]);
        end
        exp_q.push_back(e);
        if (e.taken) begin
          redir_q.push_back(e.target);
          nxt = 1'b1;
        end
      end
    end
    exp_shadow = nxt;
    if (fl) drop_pending = 1'b1;
  endtask

  task automatic sendInstr(input instr_t ins, input logic ordy);
    logic c;
    c = 1'b0;
    for (int k = 0; k < 20 && !c; k++) applyStimulus(ins, 1'b1, ordy, 1'b0, c);
    if (!c) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycle(input logic ordy);
    logic c;
    applyStimulus(mk(OPC_OP, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0), 1'b0, ordy, 1'b0, c);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (redirect_valid) begin
          if (redir_q.size() == 0) checkOutput("redirect_spurious", 32'd1, 32'd0);
          else begin
            t = redir_q.pop_front();
            checkOutput("redirect_pc", redirect_pc, t);
          end
        end
        if (out_valid) begin
          if (exp_q.size() == 0) checkOutput("out_spurious", 32'd1, 32'd0);
          else begin
            e = exp_q[0];
            if (!e.result_dc) checkOutput("out_result", out_result, e.result);
            checkOutput("out_store_data", out_store_data, e.store_data);
            checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
            checkOutput("out_wb_en", 32'(out_wb_en), 32'(e.wb));
            checkOutput("out_mem_rd", 32'(out_mem_rd), 32'(e.mrd));
            checkOutput("out_mem_wr", 32'(out_mem_wr), 32'(e.mwr));
            checkOutput("out_funct3", 32'(out_funct3), 32'(e.f3));
            checkOutput("out_illegal", 32'(out_illegal), 32'(e.ill));
            checkOutput("out_misalign", 32'(out_misalign), 32'(e.mis));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    instr_t i, x, y, a, b, c3, bne;
    logic   c;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_rd = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("rst_flags", 32'({out_wb_en, out_mem_rd, out_mem_wr, out_illegal, out_misalign}), 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, RESET_PC);
    @(negedge clk); rst = 1'b0;

    // ADD then SUB into x5
    i = mk(OPC_OP, 3'b000, 1'b0, 5'd5, 32'h100, 32'd7, 32'd3, 32'd0);
    sendInstr(i, 1'b1);
    checkOutput("add_alu_s", 32'(alu_s), 32'h01);
    i.f7 = 1'b1;
    sendInstr(i, 1'b1);
    checkOutput("sub_alu_s", 32'(alu_s), 32'h21);
    checkOutput("add_out_result", out_result, 32'd10);
    checkOutput("add_out_wb_en", 32'(out_wb_en), 32'd1);
    checkOutput("add_out_rd", 32'(out_rd), 32'd5);
    idleCycle(1'b1);
    checkOutput("sub_out_result", out_result, 32'd4);

    // SRAI and ADDI with bit 30 set
    sendInstr(mk(OPC_IMM, 3'b101, 1'b1, 5'd6, 32'h104, 32'h8000_0000, 32'd0, 32'h0000_0404), 1'b1);
    checkOutput("srai_alu_s", 32'(alu_s), 32'h35);
    idleCycle(1'b1);
    checkOutput("srai_out_result", out_result, 32'hF800_0000);
    sendInstr(mk(OPC_IMM, 3'b000, 1'b1, 5'd7, 32'h108, 32'd5, 32'd0, 32'd3), 1'b1);
    checkOutput("addi_alu_s", 32'(alu_s), 32'h01);
    idleCycle(1'b1);

    // Taken BEQ with a wrong-path instruction held behind it
    sendInstr(mk(OPC_BRANCH, 3'b000, 1'b0, 5'd0, 32'h100, 32'd9, 32'd9, 32'h20), 1'b1);
    x = mk(OPC_OP, 3'b000, 1'b0, 5'd8, 32'h104, 32'd1, 32'd1, 32'd0);
    applyStimulus(x, 1'b1, 1'b1, 1'b0, c);
    checkOutput("beq_redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h120);
    checkOutput("beq_shadow_consumed", 32'(c), 32'd1);
    y = mk(OPC_OP, 3'b000, 1'b0, 5'd9, 32'h120, 32'd20, 32'd22, 32'd0);
    applyStimulus(y, 1'b1, 1'b1, 1'b0, c);
    checkOutput("beq_pulse_width", 32'(redirect_valid), 32'd0);
    checkOutput("beq_next_accepted", 32'(c), 32'd1);
    idleCycle(1'b1);

    // JALR to a misaligned target, with and without a link register
    sendInstr(mk(OPC_JALR, 3'b000, 1'b0, 5'd1, 32'h400, 32'h203, 32'd0, 32'd0), 1'b1);
    idleCycle(1'b1);
    checkOutput("jalr_redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("jalr_redirect_pc", redirect_pc, 32'h202);
    checkOutput("jalr_misalign", 32'(out_misalign), 32'd1);
    checkOutput("jalr_out_result", out_result, 32'h404);
    checkOutput("jalr_wb_en", 32'(out_wb_en), 32'd1);
    sendInstr(mk(OPC_JALR, 3'b000, 1'b0, 5'd0, 32'h400, 32'h203, 32'd0, 32'd0), 1'b1);
    idleCycle(1'b1);
    checkOutput("jalr_rd0_wb_en", 32'(out_wb_en), 32'd0);

    // Back-pressure for three cycles, then two back-to-back instructions
    a  = mk(OPC_OP, 3'b000, 1'b0, 5'd10, 32'h500, 32'd100, 32'd1, 32'd0);
    b  = mk(OPC_OP, 3'b100, 1'b0, 5'd11, 32'h504, 32'hF0, 32'h0F, 32'd0);
    c3 = mk(OPC_OP, 3'b110, 1'b0, 5'd12, 32'h508, 32'h100, 32'h001, 32'd0);
    sendInstr(a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(b, 1'b1, 1'b0, 1'b0, c);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_result", out_result, 32'd101);
    end
    sendInstr(b, 1'b1);
    sendInstr(c3, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // flush beats a taken BNE; then flush drops a held instruction
    bne = mk(OPC_BRANCH, 3'b001, 1'b0, 5'd0, 32'h200, 32'd1, 32'd2, 32'h40);
    applyStimulus(bne, 1'b1, 1'b1, 1'b1, c);
    idleCycle(1'b0);
    checkOutput("flush_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    sendInstr(a, 1'b0);
    applyStimulus(bne, 1'b1, 1'b0, 1'b1, c);
    idleCycle(1'b0);
    checkOutput("flush_drop_held", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall
    sendInstr(a, 1'b0);
    idleCycle(1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("midrst_flags", 32'({out_wb_en, out_mem_rd, out_mem_wr, out_illegal, out_misalign}), 32'd0);
    checkOutput("midrst_redirect_pc", redirect_pc, RESET_PC);
    exp_q.delete(); redir_q.delete(); exp_shadow = 1'b0; drop_pending = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    idleCycle(1'b1);
    checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);

    // pc+4 wraps to zero
    sendInstr(mk(OPC_JAL, 3'b000, 1'b0, 5'd1, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h10), 1'b1);
    idleCycle(1'b1);
    checkOutput("wrap_out_result", out_result, 32'd0);
    checkOutput("wrap_redirect_pc", redirect_pc, 32'h0000_000C);

    // Randomized traffic; flush cycles hold out_ready low so a dropped entry is unambiguous
    for (int k = 0; k < 600; k++) begin
      logic v, fl, ordy;
      v    = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 24) == 0);
      ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      applyStimulus(rand_instr(), v, ordy, fl, c);
    end

    for (int k = 0; k < 50 && (exp_q.size() != 0 || redir_q.size() != 0 || drop_pending); k++)
      idleCycle(1'b1);
    checkOutput("drain_exp_q", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_redir_q", 32'(redir_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
